// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: whack-a-mole game sequencer.
//   clk, rst (async, active-low)
//   start           one-cycle pulse, starts a game from IDLE or OVER
//   btn_valid/pos   debounced slot press (0 top,1 left,2 center,3 right,4 bot)
//   mole_position   current mole slot (0..4)
//   guess_correct   one-cycle pulse per hit
//   guess_wrong     one-cycle pulse per wrong press or timeout miss
//   digit_1/digit_2 BCD score tens/ones, saturating at 99
//   lives           remaining lives
//   game_over       high while in OVER
module mole_game_ctrl #(
  parameter int         MOLE_CYCLES = 100000000,
  parameter int         GAP_CYCLES  = 25000000,
  parameter int         LIVES_INIT  = 3,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [2:0] btn_pos,
  output logic [2:0] mole_position,
  output logic       guess_correct,
  output logic       guess_wrong,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2,
  output logic [1:0] lives,
  output logic       game_over
);
  localparam int MAXC = (MOLE_CYCLES > GAP_CYCLES) ? MOLE_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);
  localparam logic [TW-1:0] MOLE_LAST = TW'(MOLE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP, S_OVER} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [7:0]    lfsr;

  logic       fb, btn_ok, hit, miss_btn, timeout;
  logic [2:0] cand, next_mole;
  logic [3:0] d1_inc, d2_inc;

  // taps 8,6,5,4 -> bits 7,5,4,3
  assign fb       = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign btn_ok   = btn_valid && (btn_pos < 3'd5);
  assign hit      = btn_ok && (btn_pos == mole_position);
  assign miss_btn = btn_ok && (btn_pos != mole_position);
  // >= so that a wrong press landing on the last cycle still leads to a
  // timeout on the following cycle instead of letting the timer run on
  assign timeout  = (timer >= MOLE_LAST);

  // next slot: fold 5..7 into 0..2, then step off the current slot
  always_comb begin
    cand = lfsr[2:0];
    if (cand >= 3'd5) cand = cand - 3'd5;
    next_mole = cand;
    if (cand == mole_position) next_mole = (cand == 3'd4) ? 3'd0 : cand + 3'd1;
  end

  // BCD increment, saturating at 99
  always_comb begin
    d1_inc = digit_1;
    d2_inc = digit_2;
    if (!(digit_1 == 4'd9 && digit_2 == 4'd9)) begin
      if (digit_2 == 4'd9) begin
        d2_inc = 4'd0;
        d1_inc = digit_1 + 4'd1;
      end else begin
        d2_inc = digit_2 + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      timer         <= '0;
      lfsr          <= LFSR_SEED;
      mole_position <= 3'd0;
      guess_correct <= 1'b0;
      guess_wrong   <= 1'b0;
      digit_1       <= 4'd0;
      digit_2       <= 4'd0;
      lives         <= 2'(LIVES_INIT);
      game_over     <= 1'b0;
    end else begin
      lfsr          <= {lfsr[6:0], fb};
      guess_correct <= 1'b0;
      guess_wrong   <= 1'b0;
      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            state     <= S_SHOW;
            timer     <= '0;
            digit_1   <= 4'd0;
            digit_2   <= 4'd0;
            lives     <= 2'(LIVES_INIT);
            game_over <= 1'b0;
          end
        end
        S_SHOW: begin
          timer <= timer + 1'b1;
          if (hit) begin
            guess_correct <= 1'b1;
            digit_1       <= d1_inc;
            digit_2       <= d2_inc;
            state         <= S_GAP;
            timer         <= '0;
            mole_position <= next_mole;
          end else if (miss_btn || timeout) begin
            guess_wrong <= 1'b1;
            lives       <= lives - 2'd1;
            if (lives == 2'd1) begin
              state     <= S_OVER;
              game_over <= 1'b1;
              timer     <= '0;
            end else if (!miss_btn) begin
              // timeout miss; a wrong press keeps the mole and the timer
              state         <= S_GAP;
              timer         <= '0;
              mole_position <= next_mole;
            end
          end
        end
        S_GAP: begin
          if (timer == GAP_LAST) begin
            state <= S_SHOW;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
